// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of the 7:1 select mux: picks one requester, drives the
// registered mux select and one-hot grant, and rotates after a bounded hold quantum.
module mux_rr_arbiter #(
    parameter int unsigned          N_REQ    = 7,
    parameter int unsigned          SEL_W    = 3,
    parameter int unsigned          QUANTUM  = 4,
    parameter logic [SEL_W-1:0]     IDLE_SEL = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [N_REQ-1:0]  req_i,
    output logic [SEL_W-1:0]  mux_select_o,
    output logic [N_REQ-1:0]  grant_o,
    output logic              valid_o,
    output logic [SEL_W-1:0]  grant_idx_o
);

    localparam int unsigned CNT_W = $clog2(QUANTUM + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(QUANTUM);
    localparam logic [SEL_W-1:0] RESET_IDX = SEL_W'(N_REQ - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [SEL_W-1:0]   mux_sel_q, mux_sel_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               valid_q, valid_d;

    logic [SEL_W-1:0]   winner_c;
    logic [SEL_W-1:0]   scan_idx_c;
    logic               found_c;
    logic               any_req_c;
    logic               cur_req_c;
    logic               other_req_c;
    logic               load_c;

    // Scan GrantIdx+1, +2, ... wrapping; the current index is examined last.
    always_comb begin
        winner_c   = grant_idx_q;
        found_c    = 1'b0;
        scan_idx_c = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            scan_idx_c = SEL_W'((32'(grant_idx_q) + k) % N_REQ);
            if (!found_c && req_i[scan_idx_c]) begin
                winner_c = scan_idx_c;
                found_c  = 1'b1;
            end
        end
    end

    assign any_req_c   = |req_i;
    assign cur_req_c   = req_i[grant_idx_q];
    assign other_req_c = |(req_i & ~(N_REQ'(1) << grant_idx_q));

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        hold_d      = hold_q;
        load_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i && any_req_c) begin
                    load_c = 1'b1;
                end else begin
                    hold_d = '0;
                end
            end
            S_GRANT: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                    hold_d  = '0;
                end else if (!cur_req_c) begin
                    if (any_req_c) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_MAX && other_req_c) begin
                    load_c = 1'b1;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = '0;
            end
        endcase

        if (load_c) begin
            state_d     = S_GRANT;
            grant_idx_d = winner_c;
            hold_d      = CNT_W'(1);
        end

        // Outputs follow the next state so they land in registers with the state.
        valid_d   = (state_d == S_GRANT);
        grant_d   = valid_d ? (N_REQ'(1) << grant_idx_d) : '0;
        mux_sel_d = valid_d ? grant_idx_d : IDLE_SEL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_idx_q <= RESET_IDX;
            hold_q      <= '0;
            mux_sel_q   <= IDLE_SEL;
            grant_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            hold_q      <= hold_d;
            mux_sel_q   <= mux_sel_d;
            grant_q     <= grant_d;
            valid_q     <= valid_d;
        end
    end

    assign mux_select_o = mux_sel_q;
    assign grant_o      = grant_q;
    assign valid_o      = valid_q;
    assign grant_idx_o  = grant_idx_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic compared
// against a rule-level reference model and a starvation bound.
module tb_mux_rr_arbiter;

    localparam int N  = 7;
    localparam int Q  = 4;
    localparam int IDLE_CODE = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [6:0] req;
    logic [2:0] mux_select;
    logic [6:0] grant;
    logic       valid;
    logic [2:0] grant_idx;

    int checks = 0;
    int errors = 0;

    // Reference model state: whether someone holds the grant, who, and for how long.
    bit m_valid;
    int m_idx;
    int m_hold;

    int wait_cnt [N];

    mux_rr_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .req_i        (req),
        .mux_select_o (mux_select),
        .grant_o      (grant),
        .valid_o      (valid),
        .grant_idx_o  (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_winner(input int from, input logic [6:0] rq);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (from + k) % N;
            if (rq[j]) return j;
        end
        return from;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = N - 1;
        m_hold  = 0;
    endtask

    task automatic model_step(input bit en, input logic [6:0] rq);
        logic [6:0] others;
        others = rq;
        if (!m_valid) begin
            if (en && rq != 0) begin
                m_idx = next_winner(m_idx, rq); m_valid = 1'b1; m_hold = 1;
            end
        end else if (!en) begin
            m_valid = 1'b0; m_hold = 0;
        end else if (!rq[m_idx]) begin
            if (rq != 0) begin
                m_idx = next_winner(m_idx, rq); m_hold = 1;
            end else begin
                m_valid = 1'b0; m_hold = 0;
            end
        end else begin
            others[m_idx] = 1'b0;
            if (m_hold == Q && others != 0) begin
                m_idx = next_winner(m_idx, rq); m_hold = 1;
            end else if (m_hold < Q) begin
                m_hold++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int exp_grant;
        int exp_sel;
        exp_grant = m_valid ? (1 << m_idx) : 0;
        exp_sel   = m_valid ? m_idx : IDLE_CODE;
        check({tag, "_valid"}, 32'(valid), 32'(m_valid));
        check({tag, "_grant"}, 32'(grant), 32'(exp_grant));
        check({tag, "_sel"},   32'(mux_select), 32'(exp_sel));
        check({tag, "_idx"},   32'(grant_idx), 32'(m_idx));
    endtask

    task automatic cycle(input string tag, input bit en, input logic [6:0] rq);
        enable = en;
        req    = rq;
        @(posedge clk);
        #1;
        model_step(en, rq);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int exp3 [9];
        logic [6:0] rq;
        bit en;
        int maxw;

        exp3 = '{0, 0, 0, 0, 6, 6, 6, 6, 0};
        rst = 1'b1;
        enable = 1'b0;
        req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset_idx6", 32'(grant_idx), 32'd6);
        rst = 1'b0;

        // Sole requester keeps the grant with no rotation.
        for (int i = 0; i < 20; i++) begin
            cycle("sole", 1'b1, 7'b0000100);
            check("sole_sel2", 32'(mux_select), 32'd2);
            check("sole_grant", 32'(grant), 32'h04);
        end
        cycle("sole_idle", 1'b0, 7'b0000000);

        // Quantum rotation between requesters 0 and 6.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle("quantum", 1'b1, 7'b1000001);
            check("quantum_seq", 32'(mux_select), 32'(exp3[i]));
        end
        cycle("drop0", 1'b1, 7'b1000000);
        check("drop0_sel6", 32'(mux_select), 32'd6);
        cycle("wrap", 1'b1, 7'b0000010);
        check("wrap_sel1", 32'(mux_select), 32'd1);

        // Enable drop during grant 3, then resume from pointer.
        cycle("g3", 1'b1, 7'b0001000);
        check("g3_sel", 32'(mux_select), 32'd3);
        cycle("endrop", 1'b0, 7'b0001000);
        check("endrop_valid", 32'(valid), 32'd0);
        check("endrop_sel", 32'(mux_select), 32'd7);
        check("endrop_idx", 32'(grant_idx), 32'd3);
        cycle("reen", 1'b1, 7'h7F);
        check("reen_sel4", 32'(mux_select), 32'd4);

        // Asynchronous reset mid-grant takes effect before the next edge.
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_sel", 32'(mux_select), 32'd7);
        check("arst_idx", 32'(grant_idx), 32'd6);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle("post_rst", 1'b1, 7'h7F);
        check("post_rst_sel0", 32'(mux_select), 32'd0);

        // Randomized traffic with sticky requests and occasional enable drops.
        rq = 7'h7F;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rq[i]) begin
                    if (m_valid && m_idx == i && $urandom_range(0, 2) == 0) rq[i] = 1'b0;
                    else if ($urandom_range(0, 63) == 0) rq[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    rq[i] = 1'b1;
                end
            end
            en = ($urandom_range(0, 31) != 0);
            cycle("rand", en, rq);
            maxw = 0;
            for (int i = 0; i < N; i++) begin
                if (en && rq[i] && !grant[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
            end
            check("wait_bound", 32'(maxw <= 6 * Q), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
